// File: rtl/ahb_master_if.sv
// ahb_master_if: command/response port and AHB-Lite master bus signals of ahb_master
interface ahb_master_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [2:0]        cmd_size_i;
  logic [AWIDTH-1:0] cmd_addr_i;
  logic [DWIDTH-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_err_o;
  logic [DWIDTH-1:0] rsp_rdata_o;
  logic              busy_o;
  logic [AWIDTH-1:0] haddr_o;
  logic [1:0]        htrans_o;
  logic              hwrite_o;
  logic [2:0]        hsize_o;
  logic [2:0]        hburst_o;
  logic [DWIDTH-1:0] hwdata_o;
  logic              hready_i;
  logic              hresp_i;
  logic [DWIDTH-1:0] hrdata_i;
  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_size_i, cmd_addr_i, cmd_wdata_i,
           hready_i, hresp_i, hrdata_i,
    output cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o,
           haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
  );
  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_size_i, cmd_addr_i, cmd_wdata_i,
           hready_i, hresp_i, hrdata_i,
    input  cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o,
           haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hwdata_o
  );
endinterface

// File: rtl/ahb_master.sv
// ahb_master: single-transfer AHB-Lite master with a pipelined address (A) and data (D) stage;
// one command per cycle with a zero-wait slave, responses in acceptance order.
module ahb_master #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_master_if.master bus
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [2:0] SINGLE = 3'b000;
  logic              a_valid, a_write;
  logic [AWIDTH-1:0] a_addr;
  logic [2:0]        a_size;
  logic [DWIDTH-1:0] a_wdata;
  logic              d_valid, d_write;
  logic [DWIDTH-1:0] d_wdata;
  logic              rsp_valid, rsp_err;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              cmd_ready, accept, d_done;
  assign cmd_ready = !a_valid || bus.hready_i;
  assign accept    = bus.cmd_valid_i && cmd_ready;
  assign d_done    = d_valid && bus.hready_i;
  // A and D only advance on hready; a stalled A can still be filled when empty
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_size    <= '0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_done;
      rsp_err   <= d_done && bus.hresp_i;
      rsp_rdata <= (d_done && !d_write && !bus.hresp_i) ? bus.hrdata_i : '0;
      if (bus.hready_i) begin
        d_valid <= a_valid;
        d_write <= a_write;
        d_wdata <= a_wdata;
      end
      if (accept) begin
        a_valid <= 1'b1;
        a_write <= bus.cmd_write_i;
        a_addr  <= bus.cmd_addr_i;
        a_size  <= bus.cmd_size_i;
        a_wdata <= bus.cmd_wdata_i;
      end else if (bus.hready_i) begin
        a_valid <= 1'b0;
      end
    end
  end
  assign bus.cmd_ready_o = cmd_ready;
  assign bus.htrans_o    = a_valid ? NONSEQ : IDLE;
  assign bus.haddr_o     = a_addr;
  assign bus.hwrite_o    = a_write;
  assign bus.hsize_o     = a_size;
  assign bus.hburst_o    = SINGLE;
  assign bus.hwdata_o    = d_valid ? d_wdata : '0;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.busy_o      = a_valid || d_valid;
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed steps for ahb_master; responses checked against a scoreboard queue
module tb_ahb_master;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int checks = 0;
  int failures = 0;
  int nrsp = 0;
  rsp_t sb[$];
  ahb_master_if #(.AWIDTH(32), .DWIDTH(32)) bus();
  ahb_master #(.AWIDTH(32), .DWIDTH(32)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask
  task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid_i = v;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    bus.cmd_size_i  = 3'd2;
  endtask
  task automatic push(input logic e, input logic [31:0] d);
    rsp_t r;
    r.err = e;
    r.rdata = d;
    sb.push_back(r);
  endtask
  task automatic slv(input logic rdy, input logic rsp, input logic [31:0] d);
    bus.hready_i = rdy;
    bus.hresp_i  = rsp;
    bus.hrdata_i = d;
  endtask
  always @(negedge hclk) begin
    if (bus.rsp_valid_o) begin
      nrsp++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL rsp_unexpected observed=1 expected=0");
      end
      if (sb.size() > 0) begin
        rsp_t r;
        r = sb.pop_front();
        chk("rsp_err", 64'(bus.rsp_err_o), 64'(r.err));
        chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(r.rdata));
      end
    end
  end
  initial begin
    cmd(0, 0, 0, 0);
    slv(1, 0, 0);
    nxt();
    nxt();
    #1;
    chk("rst_htrans", 64'(bus.htrans_o), 64'h0);
    chk("rst_haddr", 64'(bus.haddr_o), 64'h0);
    chk("rst_busy", 64'(bus.busy_o), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    chk("rst_hwdata", 64'(bus.hwdata_o), 64'h0);
    chk("hburst", 64'(bus.hburst_o), 64'h0);
    nxt();
    hresetn = 1'b1;
    // single write
    cmd(1, 1, 32'h10, 32'hA5A5_0001);
    push(0, 0);
    #1 chk("w1_ready", 64'(bus.cmd_ready_o), 64'h1);
    nxt();
    cmd(0, 0, 0, 0);
    #1 chk("w1_htrans", 64'(bus.htrans_o), 64'h2);
    chk("w1_haddr", 64'(bus.haddr_o), 64'h10);
    chk("w1_hwrite", 64'(bus.hwrite_o), 64'h1);
    chk("w1_hsize", 64'(bus.hsize_o), 64'h2);
    chk("w1_busy", 64'(bus.busy_o), 64'h1);
    nxt();
    #1 chk("w1_dphase_htrans", 64'(bus.htrans_o), 64'h0);
    chk("w1_hwdata", 64'(bus.hwdata_o), 64'hA5A5_0001);
    nxt();
    #1 chk("w1_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    chk("w1_idle_busy", 64'(bus.busy_o), 64'h0);
    nxt();
    // read with two wait states, a write queued behind it
    cmd(1, 0, 32'h04, 0);
    push(0, 32'hC3);
    nxt();
    cmd(0, 0, 0, 0);
    #1 chk("r2_htrans", 64'(bus.htrans_o), 64'h2);
    chk("r2_haddr", 64'(bus.haddr_o), 64'h04);
    chk("r2_hwrite", 64'(bus.hwrite_o), 64'h0);
    nxt();
    slv(0, 0, 0);
    cmd(1, 1, 32'h08, 32'h55);
    push(0, 0);
    #1 chk("r2_wait1_ready", 64'(bus.cmd_ready_o), 64'h1);
    chk("r2_wait1_hwdata", 64'(bus.hwdata_o), 64'h0);
    nxt();
    cmd(0, 0, 0, 0);
    #1 chk("r2_wait2_htrans", 64'(bus.htrans_o), 64'h2);
    chk("r2_wait2_haddr", 64'(bus.haddr_o), 64'h08);
    chk("r2_wait2_ready", 64'(bus.cmd_ready_o), 64'h0);
    chk("r2_wait2_hwdata", 64'(bus.hwdata_o), 64'h0);
    nxt();
    slv(1, 0, 32'hC3);
    #1 chk("r2_last_haddr", 64'(bus.haddr_o), 64'h08);
    chk("r2_last_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    nxt();
    slv(1, 0, 0);
    #1 chk("r2_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    chk("r2_w_hwdata", 64'(bus.hwdata_o), 64'h55);
    chk("r2_w_htrans", 64'(bus.htrans_o), 64'h0);
    nxt();
    #1 chk("r2_w_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    nxt();
    // three back-to-back writes
    cmd(1, 1, 32'h0, 32'h100);
    push(0, 0);
    nxt();
    cmd(1, 1, 32'h4, 32'h104);
    push(0, 0);
    #1 chk("b3_haddr0", 64'(bus.haddr_o), 64'h0);
    chk("b3_htrans0", 64'(bus.htrans_o), 64'h2);
    chk("b3_ready", 64'(bus.cmd_ready_o), 64'h1);
    nxt();
    cmd(1, 1, 32'h8, 32'h108);
    push(0, 0);
    #1 chk("b3_haddr1", 64'(bus.haddr_o), 64'h4);
    chk("b3_htrans1", 64'(bus.htrans_o), 64'h2);
    chk("b3_hwdata0", 64'(bus.hwdata_o), 64'h100);
    nxt();
    cmd(0, 0, 0, 0);
    #1 chk("b3_haddr2", 64'(bus.haddr_o), 64'h8);
    chk("b3_htrans2", 64'(bus.htrans_o), 64'h2);
    chk("b3_hwdata1", 64'(bus.hwdata_o), 64'h104);
    chk("b3_rsp0", 64'(bus.rsp_valid_o), 64'h1);
    nxt();
    #1 chk("b3_htrans_idle", 64'(bus.htrans_o), 64'h0);
    chk("b3_hwdata2", 64'(bus.hwdata_o), 64'h108);
    chk("b3_rsp1", 64'(bus.rsp_valid_o), 64'h1);
    nxt();
    #1 chk("b3_rsp2", 64'(bus.rsp_valid_o), 64'h1);
    nxt();
    #1 chk("b3_rsp_end", 64'(bus.rsp_valid_o), 64'h0);
    // read with a two-cycle ERROR, followed by a write
    cmd(1, 0, 32'h20, 0);
    push(1, 0);
    nxt();
    cmd(1, 1, 32'h24, 32'h77);
    push(0, 0);
    nxt();
    cmd(0, 0, 0, 0);
    slv(0, 1, 32'hDEAD);
    #1 chk("e4_err1_htrans", 64'(bus.htrans_o), 64'h2);
    chk("e4_err1_haddr", 64'(bus.haddr_o), 64'h24);
    chk("e4_err1_hwrite", 64'(bus.hwrite_o), 64'h1);
    nxt();
    slv(1, 1, 32'hDEAD);
    #1 chk("e4_err2_htrans", 64'(bus.htrans_o), 64'h2);
    chk("e4_err2_haddr", 64'(bus.haddr_o), 64'h24);
    nxt();
    slv(1, 0, 0);
    #1 chk("e4_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    chk("e4_w_hwdata", 64'(bus.hwdata_o), 64'h77);
    nxt();
    #1 chk("e4_w_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    nxt();
    // reset during the data phase of a read
    cmd(1, 0, 32'h30, 0);
    nxt();
    cmd(0, 0, 0, 0);
    nxt();
    slv(0, 0, 0);
    #1 chk("r5_busy_pre", 64'(bus.busy_o), 64'h1);
    hresetn = 1'b0;
    #1 chk("r5_htrans", 64'(bus.htrans_o), 64'h0);
    chk("r5_haddr", 64'(bus.haddr_o), 64'h0);
    chk("r5_busy", 64'(bus.busy_o), 64'h0);
    chk("r5_hwdata", 64'(bus.hwdata_o), 64'h0);
    chk("r5_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    slv(1, 0, 32'h99);
    nxt();
    nxt();
    hresetn = 1'b1;
    slv(1, 0, 0);
    cmd(1, 1, 32'h40, 32'h5);
    push(0, 0);
    #1 chk("r5_ready_after", 64'(bus.cmd_ready_o), 64'h1);
    nxt();
    cmd(0, 0, 0, 0);
    #1 chk("r5_new_htrans", 64'(bus.htrans_o), 64'h2);
    chk("r5_new_haddr", 64'(bus.haddr_o), 64'h40);
    nxt();
    nxt();
    nxt();
    nxt();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    chk("rsp_count", 64'(nrsp), 64'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
